alu_operand_stage: RTL and testbench

- Execute-entry pipeline register (ID/EX) that sits directly upstream of the ALU.
- Holds one decoded instruction and forwards operands from the EX/MEM and MEM/WB stages.
- Drives the ALU inputs `a`, `b` and the 4-bit ALU operation code, plus the side-band values needed downstream.
- Stalls on load-use hazards and supports flush.

---
 rtl/alu_operand_stage.sv | 156 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the ALU: holds one decoded instruction,
// forwards operands from EX/MEM and MEM/WB, stalls on load-use and supports flush.

module alu_operand_fwd #(
  parameter int WORD_SIZE  = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [WORD_SIZE-1:0]  held,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [WORD_SIZE-1:0]  ex_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [WORD_SIZE-1:0]  wb_data,
  output logic [WORD_SIZE-1:0]  eff,
  output logic                  hit_ex,
  output logic                  refresh
);
  logic nz, hit_wb;

  assign nz     = |addr;
  assign hit_ex = ex_valid & (ex_rd == addr) & nz;
  assign hit_wb = wb_valid & (wb_rd == addr) & nz;
  assign eff    = hit_ex ? ex_data : hit_wb ? wb_data : held;
  // a load hit in EX carries no usable data yet, so it must not overwrite the held copy
  assign refresh = hit_ex ? !ex_is_load : hit_wb;
endmodule

module alu_operand_stage #(
  parameter int WORD_SIZE  = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_SIZE-1:0]  in_pc,
  input  logic [WORD_SIZE-1:0]  in_rs1_data,
  input  logic [WORD_SIZE-1:0]  in_rs2_data,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [WORD_SIZE-1:0]  in_imm,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7_b5,
  input  logic                  in_use_pc_a,
  input  logic                  in_use_imm_b,
  input  logic                  in_force_add,
  input  logic                  flush,
  input  logic                  fwd_ex_valid,
  input  logic                  fwd_ex_is_load,
  input  logic [REG_ADDR_W-1:0] fwd_ex_rd,
  input  logic [WORD_SIZE-1:0]  fwd_ex_data,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [WORD_SIZE-1:0]  fwd_wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_SIZE-1:0]  alu_a,
  output logic [WORD_SIZE-1:0]  alu_b,
  output logic [3:0]            raw_alu_operation,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [WORD_SIZE-1:0]  out_pc,
  output logic [WORD_SIZE-1:0]  out_rs2_data
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [WORD_SIZE-1:0]  pc;
    logic [WORD_SIZE-1:0]  rs1;
    logic [WORD_SIZE-1:0]  rs2;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_SIZE-1:0]  imm;
    logic [2:0]            funct3;
    logic                  funct7_b5;
    logic                  use_pc_a;
    logic                  use_imm_b;
    logic                  force_add;
  } entry_t;

  entry_t q, d_in;
  logic   valid_q;
  logic   hz, advance, capture;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_addr;
  logic [NUM_OPS-1:0][WORD_SIZE-1:0]  op_held, op_eff;
  logic [NUM_OPS-1:0]                 op_hit_ex, op_refresh;

  assign d_in = '{pc: in_pc, rs1: in_rs1_data, rs2: in_rs2_data,
                  rs1_addr: in_rs1_addr, rs2_addr: in_rs2_addr, rd: in_rd_addr,
                  imm: in_imm, funct3: in_funct3, funct7_b5: in_funct7_b5,
                  use_pc_a: in_use_pc_a, use_imm_b: in_use_imm_b,
                  force_add: in_force_add};

  assign op_addr = {q.rs2_addr, q.rs1_addr};
  assign op_held = {q.rs2, q.rs1};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    alu_operand_fwd #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) u_fwd (
      .addr      (op_addr[i]),
      .held      (op_held[i]),
      .ex_valid  (fwd_ex_valid),
      .ex_is_load(fwd_ex_is_load),
      .ex_rd     (fwd_ex_rd),
      .ex_data   (fwd_ex_data),
      .wb_valid  (fwd_wb_valid),
      .wb_rd     (fwd_wb_rd),
      .wb_data   (fwd_wb_data),
      .eff       (op_eff[i]),
      .hit_ex    (op_hit_ex[i]),
      .refresh   (op_refresh[i])
    );
  end

  // rs2 is checked even for immediate forms since it may be store data
  assign hz = valid_q & fwd_ex_is_load & ((op_hit_ex[0] & !q.use_pc_a) | op_hit_ex[1]);

  assign out_valid = valid_q & !hz;
  assign advance   = out_valid & out_ready;
  assign in_ready  = !valid_q | advance;
  assign capture   = in_valid & in_ready & !flush;

  assign alu_a        = q.use_pc_a  ? q.pc  : op_eff[0];
  assign alu_b        = q.use_imm_b ? q.imm : op_eff[1];
  assign out_rs2_data = op_eff[1];
  assign out_rd_addr  = q.rd;
  assign out_pc       = q.pc;

  always_comb begin
    raw_alu_operation = 4'b0000;
    if (!q.force_add)
      raw_alu_operation = {(!q.use_imm_b || q.funct3 == 3'b101) & q.funct7_b5, q.funct3};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      q       <= d_in;
    end else if (advance) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      // keep producers that retire past WB while we stall
      if (op_refresh[0]) q.rs1 <= op_eff[0];
      if (op_refresh[1]) q.rs2 <= op_eff[1];
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected ALU inputs queued at capture, checked at issue.

module tb_alu_operand_stage;
  localparam int W = 32;
  localparam int A = 5;

  logic          clk = 0;
  logic          reset, in_valid, in_ready;
  logic [W-1:0]  in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [A-1:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [2:0]    in_funct3;
  logic          in_funct7_b5, in_use_pc_a, in_use_imm_b, in_force_add, flush;
  logic          fwd_ex_valid, fwd_ex_is_load, fwd_wb_valid;
  logic [A-1:0]  fwd_ex_rd, fwd_wb_rd;
  logic [W-1:0]  fwd_ex_data, fwd_wb_data;
  logic          out_valid, out_ready;
  logic [W-1:0]  alu_a, alu_b, out_pc, out_rs2_data;
  logic [3:0]    raw_alu_operation;
  logic [A-1:0]  out_rd_addr;

  typedef struct {
    logic [W-1:0] a, b, pc, rs2;
    logic [3:0]   op;
    logic [A-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  int   n_vec = 0, n_err = 0, n_push = 0, n_pop = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.WORD_SIZE(W), .REG_ADDR_W(A)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_imm(in_imm), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
    .in_use_pc_a(in_use_pc_a), .in_use_imm_b(in_use_imm_b), .in_force_add(in_force_add),
    .flush(flush), .fwd_ex_valid(fwd_ex_valid), .fwd_ex_is_load(fwd_ex_is_load),
    .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data), .fwd_wb_valid(fwd_wb_valid),
    .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .raw_alu_operation(raw_alu_operation), .out_rd_addr(out_rd_addr),
    .out_pc(out_pc), .out_rs2_data(out_rs2_data)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // negedge: retire issued entries against the scoreboard, record captures
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_issue", 32'(out_valid), 0);
      else begin
        e = exp_q.pop_front();
        n_pop++;
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("op", 32'(raw_alu_operation), 32'(e.op));
        chk("rd", 32'(out_rd_addr), 32'(e.rd));
        chk("pc", out_pc, e.pc);
        chk("rs2_data", out_rs2_data, e.rs2);
      end
    end
    if (in_valid && in_ready && !flush && !reset) begin
      exp_q.push_back(pend);
      n_push++;
    end
    if (flush || reset) exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic fwd_clear();
    fwd_ex_valid = 0; fwd_ex_is_load = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task automatic offer(input logic [W-1:0] pc, input logic [A-1:0] r1a, input logic [W-1:0] r1d,
                       input logic [A-1:0] r2a, input logic [W-1:0] r2d, input logic [A-1:0] rd,
                       input logic [W-1:0] imm, input logic [2:0] f3, input logic b5,
                       input logic upa, input logic uib, input logic fa,
                       input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input logic [3:0] eop, input logic [W-1:0] ers2);
    in_valid = 1; in_pc = pc; in_rs1_addr = r1a; in_rs1_data = r1d;
    in_rs2_addr = r2a; in_rs2_data = r2d; in_rd_addr = rd; in_imm = imm;
    in_funct3 = f3; in_funct7_b5 = b5; in_use_pc_a = upa; in_use_imm_b = uib;
    in_force_add = fa;
    pend.a = ea; pend.b = eb; pend.op = eop; pend.rd = rd; pend.pc = pc; pend.rs2 = ers2;
  endtask

  initial begin
    reset = 1; flush = 0; out_ready = 1; in_valid = 0;
    in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_funct3 = 0; in_funct7_b5 = 0; in_use_pc_a = 0; in_use_imm_b = 0; in_force_add = 0;
    pend = '{default: '0};
    fwd_clear();
    tick(); tick();
    reset = 0;

    sample();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_op", 32'(raw_alu_operation), 0);
    chk("rst_rd", 32'(out_rd_addr), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_rs2", out_rs2_data, 0);
    tick();

    // back-to-back stream: ADD, SUB, SRAI, ADDI(b5=1), forced-add with funct3=101
    offer(32'h100, 1, 5, 2, 7, 3, 0, 3'b000, 0, 0, 0, 0, 5, 7, 4'b0000, 7);
    sample(); chk("stream_rdy0", 32'(in_ready), 1); tick();
    offer(32'h104, 1, 9, 2, 4, 5, 0, 3'b000, 1, 0, 0, 0, 9, 4, 4'b1000, 4);
    sample(); chk("stream_rdy1", 32'(in_ready), 1); chk("stream_v1", 32'(out_valid), 1); tick();
    offer(32'h108, 6, 32'h80, 0, 0, 8, 3, 3'b101, 1, 0, 1, 0, 32'h80, 3, 4'b1101, 0);
    sample(); chk("stream_rdy2", 32'(in_ready), 1); chk("stream_v2", 32'(out_valid), 1); tick();
    offer(32'h10c, 7, 1, 9, 2, 10, 32'hffff_ffff, 3'b000, 1, 0, 1, 0, 1, 32'hffff_ffff, 4'b0000, 2);
    sample(); chk("stream_rdy3", 32'(in_ready), 1); chk("stream_v3", 32'(out_valid), 1); tick();
    offer(32'h110, 0, 0, 0, 0, 11, 32'h40, 3'b101, 1, 1, 1, 1, 32'h110, 32'h40, 4'b0000, 0);
    step();
    in_valid = 0;
    step();

    // forwarding priority: EX beats WB; index 0 never forwards
    offer(32'h200, 4, 32'h11, 0, 32'h33, 12, 0, 3'b000, 0, 0, 0, 0, 32'hAA, 32'h33, 4'b0000, 32'h33);
    step();
    in_valid = 0;
    fwd_ex_valid = 1; fwd_ex_rd = 4; fwd_ex_data = 32'hAA;
    fwd_wb_valid = 1; fwd_wb_rd = 4; fwd_wb_data = 32'hBB;
    step();
    fwd_clear();
    offer(32'h204, 0, 32'h22, 0, 32'h44, 13, 0, 3'b000, 0, 0, 0, 0, 32'h22, 32'h44, 4'b0000, 32'h44);
    step();
    in_valid = 0;
    fwd_ex_valid = 1; fwd_ex_rd = 0; fwd_ex_data = 32'hAA;
    fwd_wb_valid = 1; fwd_wb_rd = 0; fwd_wb_data = 32'hBB;
    step();
    fwd_clear();

    // load-use on rs2, then a one-cycle WB producer must be captured by refresh
    offer(32'h300, 1, 1, 6, 32'h99, 14, 0, 3'b000, 0, 0, 0, 0, 1, 32'h55, 4'b0000, 32'h55);
    step();
    in_valid = 0;
    fwd_ex_valid = 1; fwd_ex_is_load = 1; fwd_ex_rd = 6; fwd_ex_data = 32'hDEAD;
    sample();
    chk("hz_out_valid", 32'(out_valid), 0);
    chk("hz_in_ready", 32'(in_ready), 0);
    tick();
    fwd_clear();
    fwd_wb_valid = 1; fwd_wb_rd = 6; fwd_wb_data = 32'h55;
    out_ready = 0;
    sample();
    chk("hz_clear_valid", 32'(out_valid), 1);
    tick();
    fwd_clear();
    out_ready = 1;
    step();

    // downstream stall: outputs hold, new input refused until release
    offer(32'h400, 2, 32'h1234, 3, 32'h5678, 15, 0, 3'b010, 0, 0, 0, 0, 32'h1234, 32'h5678, 4'b0010, 32'h5678);
    step();
    offer(32'h404, 1, 32'h21, 2, 32'h12, 16, 0, 3'b111, 0, 0, 0, 0, 32'h21, 32'h12, 4'b0111, 32'h12);
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_alu_a", alu_a, 32'h1234);
      chk("stall_alu_b", alu_b, 32'h5678);
      tick();
    end
    out_ready = 1;
    step();
    in_valid = 0;
    step();

    // flush with a held entry and a simultaneous offer: both disappear
    offer(32'h500, 1, 1, 2, 2, 17, 0, 3'b000, 0, 0, 0, 0, 1, 2, 4'b0000, 2);
    step();
    offer(32'h504, 3, 3, 4, 4, 18, 0, 3'b000, 0, 0, 0, 0, 3, 4, 4'b0000, 4);
    out_ready = 0; flush = 1;
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    sample();
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    tick();

    // reset in the middle of a load-use stall
    offer(32'h600, 7, 7, 0, 0, 19, 0, 3'b000, 0, 0, 0, 0, 7, 0, 4'b0000, 0);
    step();
    in_valid = 0;
    fwd_ex_valid = 1; fwd_ex_is_load = 1; fwd_ex_rd = 7;
    sample(); chk("rst_stall_hz", 32'(out_valid), 0); tick();
    reset = 1;
    step();
    reset = 0;
    fwd_clear();
    sample();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    tick();

    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("issued_count", 32'(n_pop), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
